// File: rtl/ip_ram_init_ctrl.sv
// RAM initialisation sequencer: walks an address range, writing a data pattern.
// Optional IP_RAM_INIT_AUTO_START_EN: full constant-fill pass right after reset.
module ip_ram_init_ctrl #(
  parameter int DEPTH     = 32,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = $clog2(DEPTH)
) (
  input  logic                 clockCore,
  input  logic                 resetCore,
  input  logic                 initReq,
  input  logic [1:0]           initMode,
  input  logic [DATAWIDTH-1:0] initValue,
  input  logic [ADDRWIDTH-1:0] initStartAddr,
  input  logic [ADDRWIDTH-1:0] initEndAddr,
  input  logic                 initWrReady,
  output logic                 initEnWr,
  output logic [ADDRWIDTH-1:0] initWrAddr,
  output logic [DATAWIDTH-1:0] initWrData,
  output logic                 initBusy,
  output logic                 initDone,
  output logic                 initErr
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDRWIDTH:0] LAST = (ADDRWIDTH+1)'(DEPTH-1);

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [ADDRWIDTH-1:0] end_q, end_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [1:0]           mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 auto_q;
  logic                 req;
  logic                 valid;
  logic [1:0]           req_mode;
  logic [ADDRWIDTH-1:0] req_start;
  logic [ADDRWIDTH-1:0] req_end;
  logic [DATAWIDTH-1:0] seed;
  logic [DATAWIDTH-1:0] next_data;

`ifdef IP_RAM_INIT_AUTO_START_EN
  // One-cycle synthetic request on the first clock after reset release
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) auto_q <= 1'b1;
    else           auto_q <= 1'b0;
  end
`else
  assign auto_q = 1'b0;
`endif

  always_comb begin
    req       = initReq | auto_q;
    req_mode  = auto_q ? 2'd0 : initMode;
    req_start = auto_q ? '0 : initStartAddr;
    req_end   = auto_q ? LAST[ADDRWIDTH-1:0] : initEndAddr;
    valid     = (req_start <= req_end) && ({1'b0, req_end} <= LAST);
    seed      = (req_mode == 2'd2) ? DATAWIDTH'(req_start) : initValue;
  end

  // Next pattern word derives from the current one, so no write index is kept
  always_comb begin
    next_data = data_q;
    unique case (mode_q)
      2'd0: next_data = data_q;
      2'd1: next_data = data_q + DATAWIDTH'(1);
      2'd2: next_data = DATAWIDTH'(addr_q + ADDRWIDTH'(1));
      2'd3: next_data = ~data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    addr_d  = addr_q;
    end_d   = end_q;
    data_d  = data_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && valid) begin
          state_d = RUN;
          en_d    = 1'b1;
          addr_d  = req_start;
          end_d   = req_end;
          data_d  = seed;
          mode_d  = req_mode;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else if (req) begin
          err_d   = 1'b1;
        end
      end
      RUN: begin
        if (initWrReady) begin
          if (addr_q == end_q) begin
            state_d = IDLE;
            en_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDRWIDTH'(1);
            data_d  = next_data;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      end_q   <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign initEnWr   = en_q;
  assign initWrAddr = addr_q;
  assign initWrData = data_q;
  assign initBusy   = busy_q;
  assign initDone   = done_q;
  assign initErr    = err_q;

endmodule

// File: tb/tb_ip_ram_init_ctrl.sv
// Randomised bench for ip_ram_init_ctrl against a write-list reference model.
// ADDRWIDTH is widened to 4 so an out-of-range end address can be presented.
module tb_ip_ram_init_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic          clockCore = 1'b0;
  logic          resetCore = 1'b1;
  logic          initReq = 1'b0;
  logic [1:0]    initMode = 2'd0;
  logic [DW-1:0] initValue = '0;
  logic [AW-1:0] initStartAddr = '0;
  logic [AW-1:0] initEndAddr = '0;
  logic          initWrReady = 1'b1;
  logic          initEnWr;
  logic [AW-1:0] initWrAddr;
  logic [DW-1:0] initWrData;
  logic          initBusy;
  logic          initDone;
  logic          initErr;

  int total = 0;
  int bad = 0;

  ip_ram_init_ctrl #(.DEPTH(DEPTH), .DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clockCore(clockCore),
    .resetCore(resetCore),
    .initReq(initReq),
    .initMode(initMode),
    .initValue(initValue),
    .initStartAddr(initStartAddr),
    .initEndAddr(initEndAddr),
    .initWrReady(initWrReady),
    .initEnWr(initEnWr),
    .initWrAddr(initWrAddr),
    .initWrData(initWrData),
    .initBusy(initBusy),
    .initDone(initDone),
    .initErr(initErr)
  );

  always #5 clockCore = ~clockCore;

  function automatic logic [DW-1:0] exp_data(input logic [1:0] m,
      input logic [DW-1:0] v, input int s, input int k);
    case (m)
      2'd0: return v;
      2'd1: return v + DW'(k);
      2'd2: return DW'(s + k);
      default: return (k % 2 == 1) ? ~v : v;
    endcase
  endfunction

  task automatic check_idle(input string name, input logic done_exp);
    total++;
    if (initEnWr !== 1'b0 || initBusy !== 1'b0 || initDone !== done_exp ||
        initWrAddr !== '0 || initWrData !== '0 || initErr !== 1'b0) begin
      bad++;
      $display("FAIL %s: en=%b busy=%b done=%b addr=%h data=%h err=%b, want idle done=%b",
        name, initEnWr, initBusy, initDone, initWrAddr, initWrData, initErr, done_exp);
    end
  endtask

  // Expects a pass already requested at the preceding edge; rmode 0=ready
  // always, 1=toggle starting high, 2=random; noise drives ignored inputs.
  task automatic monitor_pass(input string name, input logic [1:0] m,
      input logic [DW-1:0] v, input int s, input int e,
      input int rmode, input bit noise);
    int k = 0;
    int n = e - s + 1;
    int cyc = 0;
    bit ph = 1'b1;
    logic [DW-1:0] ed;
    while (k < n && cyc < 200) begin
      @(negedge clockCore);
      cyc++;
      initReq = 1'b0;
      initWrReady = (rmode == 0) ? 1'b1 : (rmode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      if (noise) begin
        initReq = 1'($urandom_range(0, 1)) | (k == n - 1);
        initMode = 2'($urandom);
        initValue = $urandom;
        initStartAddr = AW'($urandom_range(0, 7));
        initEndAddr = AW'($urandom_range(0, 7));
      end
      ed = exp_data(m, v, s, k);
      total++;
      if (initEnWr !== 1'b1 || initWrAddr !== AW'(s + k) || initWrData !== ed ||
          initBusy !== 1'b1 || initDone !== 1'b0) begin
        bad++;
        $display("FAIL %s write %0d: en=%b addr=%h data=%h busy=%b done=%b, want addr=%h data=%h",
          name, k, initEnWr, initWrAddr, initWrData, initBusy, initDone, AW'(s + k), ed);
      end
      if (initWrReady) k++;
    end
    total++;
    if (k < n) begin
      bad++;
      $display("FAIL %s timeout: got %0d writes, want %0d", name, k, n);
    end
    @(negedge clockCore);
    initReq = 1'b0;
    check_idle({name, " end"}, 1'b1);
    @(negedge clockCore);
    check_idle({name, " stay"}, 1'b1);
  endtask

  task automatic run_pass(input string name, input logic [1:0] m,
      input logic [DW-1:0] v, input int s, input int e,
      input int rmode, input bit noise);
    @(negedge clockCore);
    initMode = m;
    initValue = v;
    initStartAddr = AW'(s);
    initEndAddr = AW'(e);
    initReq = 1'b1;
    monitor_pass(name, m, v, s, e, rmode, noise);
  endtask

  task automatic expect_quiet(input string name, input logic done_exp);
    for (int i = 0; i < 3; i++) begin
      @(negedge clockCore);
      check_idle(name, done_exp);
    end
  endtask

  task automatic test_reset;
    initValue = 32'h0000_00C3;
    #1;
    check_idle("reset", 1'b0);
    @(negedge clockCore);
    resetCore = 1'b0;
`ifdef IP_RAM_INIT_AUTO_START_EN
    monitor_pass("autostart", 2'd0, 32'h0000_00C3, 0, DEPTH - 1, 0, 1'b0);
`else
    expect_quiet("post reset", 1'b0);
`endif
  endtask

  task automatic test_constant;
    run_pass("const", 2'd0, 32'h5A, 0, 7, 0, 1'b0);
  endtask

  task automatic test_increment_wrap;
    run_pass("incr", 2'd1, 32'hFFFF_FFFE, 2, 4, 0, 1'b0);
  endtask

  task automatic test_alternate_toggle;
    run_pass("alt", 2'd3, 32'h0F, 0, 3, 1, 1'b0);
  endtask

  task automatic test_single_write;
    run_pass("single", 2'd2, 32'h1234, 5, 5, 0, 1'b0);
  endtask

  task automatic test_range_error;
    int st[4] = '{5, 0, 7, 2};
    int en[4] = '{3, 8, 15, 1};
    logic prev;
    for (int i = 0; i < 4; i++) begin
      @(negedge clockCore);
      prev = initDone;
      initStartAddr = AW'(st[i]);
      initEndAddr = AW'(en[i]);
      initReq = 1'b1;
      @(negedge clockCore);
      initReq = 1'b0;
      total++;
      if (initErr !== 1'b1 || initEnWr !== 1'b0 || initDone !== prev) begin
        bad++;
        $display("FAIL err %0d: err=%b en=%b done=%b, want err=1 en=0 done=%b",
          i, initErr, initEnWr, initDone, prev);
      end
      @(negedge clockCore);
      check_idle("err clear", prev);
    end
  endtask

  task automatic test_req_in_run;
    run_pass("noise", 2'd1, 32'h100, 1, 6, 2, 1'b1);
    run_pass("after", 2'd0, 32'hAB, 3, 4, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      int s = $urandom_range(0, 7);
      int e = $urandom_range(s, 7);
      run_pass("rand", 2'($urandom), $urandom, s, e, 2, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc = 0;
    @(negedge clockCore);
    initMode = 2'd1;
    initValue = 32'h77;
    initStartAddr = 0;
    initEndAddr = 7;
    initReq = 1'b1;
    initWrReady = 1'b1;
    @(negedge clockCore);
    initReq = 1'b0;
    while (initWrAddr !== AW'(3) && cyc < 20) begin
      @(negedge clockCore);
      cyc++;
    end
    total++;
    if (initWrAddr !== AW'(3) || initEnWr !== 1'b1) begin
      bad++;
      $display("FAIL midrun reach: addr=%h en=%b, want addr=3 en=1", initWrAddr, initEnWr);
    end
    #2 resetCore = 1'b1;
    #1;
    check_idle("midrun reset", 1'b0);
    initValue = 32'h9;
    @(negedge clockCore);
    resetCore = 1'b0;
`ifdef IP_RAM_INIT_AUTO_START_EN
    monitor_pass("midrun auto", 2'd0, 32'h9, 0, DEPTH - 1, 0, 1'b0);
`else
    expect_quiet("midrun quiet", 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_constant();
    test_increment_wrap();
    test_alternate_toggle();
    test_single_write();
    test_range_error();
    test_req_in_run();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
